fetch_ctrl: RTL

Sequences the PC register and the instruction-memory port for the single-issue RV32I core. Drives the PC register's write enable and next value, and issues one instruction-memory request at a time over a req/ack handshake. Holds one fetched instruction for decode under a valid/stall handshake. Applies branch/jump redirects and trap entries, discarding any in-flight or buffered wrong-path instruction.

---
 rtl/core_pkg.sv | 15 +
 rtl/pc_next_mux.sv | 38 +++
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DROP
  } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Priority mux for the PC register write port: trap, then redirect, then
// sequential advance on an accepted fetch. Result is always word aligned.
module pc_next_mux
  import core_pkg::*;
(
  input  logic            en,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            accept,
  input  logic [XLEN-1:0] pc,
  output logic            wren,
  output logic [XLEN-1:0] pc_next
);

  logic [XLEN-1:0] target;

  // Select the write target; en is low while the core is held in reset.
  always_comb begin
    wren   = 1'b0;
    target = pc + PC_INC;
    if (en) begin
      if (trap_valid) begin
        wren   = 1'b1;
        target = trap_pc;
      end else if (redirect_valid) begin
        wren   = 1'b1;
        target = redirect_pc;
      end else if (accept) begin
        wren   = 1'b1;
        target = pc + PC_INC;
      end
    end
    pc_next = {target[XLEN-1:2], 2'b00};
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request, a single-entry
// instruction buffer for decode, and flush handling for redirects and traps.
module fetch_ctrl
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_pc_wren,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_pc
);

  fetch_state_e state;
  logic flush;
  logic accept;
  logic [XLEN-1:0] issue_addr;

  assign flush  = i_trap_valid | i_redirect_valid;
  assign accept = (state == S_FETCH) & i_imem_ack & ~flush;

  // A new request goes to the PC being written this cycle if there is one,
  // otherwise to the PC register as it stands.
  assign issue_addr = o_pc_wren ? o_pc_next : i_pc;

  pc_next_mux u_pc_next_mux (
    .en             (i_rst),
    .trap_valid     (i_trap_valid),
    .trap_pc        (i_trap_pc),
    .redirect_valid (i_redirect_valid),
    .redirect_pc    (i_redirect_pc),
    .accept         (accept),
    .pc             (i_pc),
    .wren           (o_pc_wren),
    .pc_next        (o_pc_next)
  );

  // Fetch FSM with registered request and instruction-buffer outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= S_IDLE;
      o_imem_req    <= 1'b0;
      o_imem_addr   <= '0;
      o_instr_valid <= 1'b0;
      o_instr       <= NOP_INSTR;
      o_instr_pc    <= '0;
    end else begin
      // Any flush kills the buffered instruction, whatever the state.
      if (flush) begin
        o_instr_valid <= 1'b0;
        o_instr       <= NOP_INSTR;
      end
      case (state)
        S_IDLE: begin
          state       <= S_FETCH;
          o_imem_req  <= 1'b1;
          o_imem_addr <= issue_addr;
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            if (!flush) begin
              o_instr       <= i_imem_rdata;
              o_instr_pc    <= o_imem_addr;
              o_instr_valid <= 1'b1;
              o_imem_req    <= 1'b0;
              state         <= S_WAIT;
            end else begin
              // Wrong-path data: reissue straight away at the flush target.
              o_imem_req  <= 1'b1;
              o_imem_addr <= issue_addr;
              state       <= S_FETCH;
            end
          end else if (flush) begin
            // The request must complete before a new one can go out.
            state <= S_DROP;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state       <= S_FETCH;
            o_imem_req  <= 1'b1;
            o_imem_addr <= issue_addr;
          end else if (!i_stall) begin
            o_instr_valid <= 1'b0;
            o_instr       <= NOP_INSTR;
            state         <= S_FETCH;
            o_imem_req    <= 1'b1;
            o_imem_addr   <= issue_addr;
          end
        end
        S_DROP: begin
          if (i_imem_ack) begin
            state       <= S_FETCH;
            o_imem_req  <= 1'b1;
            o_imem_addr <= issue_addr;
          end
        end
        default: begin
          state      <= S_IDLE;
          o_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
